clint_bus_arb: RTL and testbench

CLINT_BUS_ARB -- requirements
Module: clint_bus_arb

---
 rtl/clint_bus_arb_pkg.sv | 19 +
 rtl/clint_arb_pick.sv | 31 +++
 rtl/clint_bus_arb.sv | 157 +++++++++++++++
 tb/tb_clint_bus_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_bus_arb_pkg.sv
// rtl/clint_bus_arb_pkg.sv - shared types and constants for the CLINT bus arbiter
// Purpose: FSM state encoding, slave response codes and master-id constants
//          used by clint_bus_arb and clint_arb_pick.
// Ports:   none (package).
package clint_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Master ids double as the grant / pointer encoding.
  localparam logic MID_FETCH = 1'b0;
  localparam logic MID_LSU   = 1'b1;

endpackage

// File: rtl/clint_arb_pick.sv
// rtl/clint_arb_pick.sv - combinational two-way grant for the CLINT bus arbiter
// Purpose: chooses which master to grant from the two valids and a tie-break
//          pointer. The tie-break policy lives entirely in the pointer value
//          supplied by the parent (rotating or tied to the load/store master).
// Ports:   i_valid0/i_valid1 - request valids of master 0 (fetch) / 1 (load/store)
//          i_ptr             - master that wins when both are valid
//          o_any             - at least one request present
//          o_gnt             - granted master id (meaningful only with o_any)
module clint_arb_pick
  import clint_bus_arb_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_ptr,
  output logic o_any,
  output logic o_gnt
);

  always_comb begin
    o_any = i_valid0 | i_valid1;
    o_gnt = MID_LSU;
    if (i_valid0 && i_valid1) begin
      o_gnt = i_ptr;
    end else if (i_valid0) begin
      o_gnt = MID_FETCH;
    end else begin
      o_gnt = MID_LSU;
    end
  end

endmodule

// File: rtl/clint_bus_arb.sv
// rtl/clint_bus_arb.sv - two-master to one-slave arbiter in front of the CLINT
// Purpose: serialises fetch (m0) and load/store (m1) requests onto the single
//          timer/soft-interrupt slave port, one transaction at a time
//          (IDLE -> BUSY -> DONE).
// Config:  CLINT_ARB_RR_EN defined   - round-robin tie-break, pointer flips
//                                      after every completed transaction.
//          CLINT_ARB_RR_EN undefined - fixed priority, load/store master wins.
// Ports:   clk, rst (synchronous, active-high)
//          mN_valid_i/req_i/addr_i/wdata_i/wstrb_i - master N request (N=0,1)
//          mN_ready_o/rdata_o/resp_o               - master N completion pulse + data
//          s_valid_o/req_o/addr_o/wdata_o/wstrb_o  - request to the slave
//          s_ready_i/rdata_i/resp_i                - slave completion
module clint_bus_arb
  import clint_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_valid_i,
  input  logic                m0_req_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ready_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic [1:0]          m0_resp_o,

  input  logic                m1_valid_i,
  input  logic                m1_req_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ready_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic [1:0]          m1_resp_o,

  output logic                s_valid_o,
  output logic                s_req_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ready_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic [1:0]          s_resp_i
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          r_state;
  logic                r_win;
  logic                r_req;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_s_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_resp;
  logic                r_m0_ready;
  logic                r_m1_ready;

  logic                w_any;
  logic                w_gnt;
  logic                w_ptr;

`ifdef CLINT_ARB_RR_EN
  logic                r_ptr;
  assign w_ptr = r_ptr;
`else
  // Fixed priority: the tie-break always points at the load/store master.
  assign w_ptr = MID_LSU;
`endif

  clint_arb_pick u_pick (
    .i_valid0 (m0_valid_i),
    .i_valid1 (m1_valid_i),
    .i_ptr    (w_ptr),
    .o_any    (w_any),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_win      <= MID_FETCH;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_s_valid  <= 1'b0;
      r_rdata    <= '0;
      r_resp     <= RESP_OKAY;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
`ifdef CLINT_ARB_RR_EN
      r_ptr      <= MID_LSU;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            // Latch the winner's payload; the slave port is fed only from
            // these registers so the masters may not disturb it mid-transfer.
            r_win     <= w_gnt;
            r_req     <= w_gnt ? m1_req_i   : m0_req_i;
            r_addr    <= w_gnt ? m1_addr_i  : m0_addr_i;
            r_wdata   <= w_gnt ? m1_wdata_i : m0_wdata_i;
            r_wstrb   <= w_gnt ? m1_wstrb_i : m0_wstrb_i;
            r_s_valid <= 1'b1;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ready_i) begin
            r_rdata    <= s_rdata_i;
            r_resp     <= s_resp_i;
            r_s_valid  <= 1'b0;
            r_m0_ready <= (r_win == MID_FETCH);
            r_m1_ready <= (r_win == MID_LSU);
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
`ifdef CLINT_ARB_RR_EN
          r_ptr      <= ~r_win;
`endif
          r_state    <= ST_IDLE;
        end
        default: begin
          r_s_valid  <= 1'b0;
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_valid_o  = r_s_valid;
  assign s_req_o    = r_req;
  assign s_addr_o   = r_addr;
  assign s_wdata_o  = r_wdata;
  assign s_wstrb_o  = r_wstrb;

  // Both masters see the captured data; only the winner's ready qualifies it.
  assign m0_ready_o = r_m0_ready;
  assign m0_rdata_o = r_rdata;
  assign m0_resp_o  = r_resp;
  assign m1_ready_o = r_m1_ready;
  assign m1_rdata_o = r_rdata;
  assign m1_resp_o  = r_resp;

endmodule

// File: tb/tb_clint_bus_arb.sv
// tb/tb_clint_bus_arb.sv - scoreboard testbench for clint_bus_arb
module tb_clint_bus_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_valid_i = 1'b0, m0_req_i = 1'b0;
  logic [63:0] m0_addr_i = '0, m0_wdata_i = '0;
  logic [7:0]  m0_wstrb_i = '0;
  logic        m0_ready_o;
  logic [63:0] m0_rdata_o;
  logic [1:0]  m0_resp_o;

  logic        m1_valid_i = 1'b0, m1_req_i = 1'b0;
  logic [63:0] m1_addr_i = '0, m1_wdata_i = '0;
  logic [7:0]  m1_wstrb_i = '0;
  logic        m1_ready_o;
  logic [63:0] m1_rdata_o;
  logic [1:0]  m1_resp_o;

  logic        s_valid_o, s_req_o;
  logic [63:0] s_addr_o, s_wdata_o;
  logic [7:0]  s_wstrb_o;
  logic        s_ready_i = 1'b0;
  logic [63:0] s_rdata_i = '0;
  logic [1:0]  s_resp_i = '0;

  clint_bus_arb #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .m0_valid_i(m0_valid_i), .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o),
    .m0_rdata_o(m0_rdata_o), .m0_resp_o(m0_resp_o),
    .m1_valid_i(m1_valid_i), .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o),
    .m1_rdata_o(m1_rdata_o), .m1_resp_o(m1_resp_o),
    .s_valid_o(s_valid_o), .s_req_o(s_req_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i),
    .s_rdata_i(s_rdata_i), .s_resp_i(s_resp_i)
  );

  always #5 clk = ~clk;

  // Scoreboard queues: slave-side requests in grant order, completions in order.
  logic        q_rreq[$];
  logic [63:0] q_raddr[$], q_rwdata[$];
  logic [7:0]  q_rwstrb[$];
  logic        q_cid[$];
  logic [63:0] q_crdata[$];
  logic [1:0]  q_cresp[$];
  int          q_ccyc[$];

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  tmo = 0;
  bit  done = 1'b0;
  int  g_wait = 0;
  logic [1:0] g_resp = 2'b00;

  function automatic logic [63:0] slv_data(input logic [63:0] a);
    return (a == 64'hbff8) ? 64'h1234 : (a ^ 64'h5A5A_0000_0000_0000);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: answers after g_wait stall cycles in BUSY.
  int wcnt = 0;
  always @(negedge clk) begin
    if (rst || !s_valid_o) begin
      s_ready_i = 1'b0;
      wcnt = 0;
    end else if (!s_ready_i) begin
      if (wcnt >= g_wait) begin
        s_ready_i = 1'b1;
        s_rdata_i = slv_data(s_addr_o);
        s_resp_i  = g_resp;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic        in_busy = 1'b0;
    logic        sn_req;
    logic [63:0] sn_addr, sn_wdata;
    logic [7:0]  sn_wstrb;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        chk("rst_s_valid", {63'd0, s_valid_o}, 64'd0);
        chk("rst_m0_ready", {63'd0, m0_ready_o}, 64'd0);
        chk("rst_m1_ready", {63'd0, m1_ready_o}, 64'd0);
        chk("rst_m0_rdata", m0_rdata_o, 64'd0);
        chk("rst_m1_resp", {62'd0, m1_resp_o}, 64'd0);
        chk("rst_s_addr", s_addr_o, 64'd0);
        chk("rst_s_wdata", s_wdata_o, 64'd0);
        in_busy = 1'b0;
        continue;
      end
      if (s_valid_o) begin
        if (!in_busy) begin
          if (q_raddr.size() == 0) begin
            chk("unexpected_grant", 64'd1, 64'd0);
          end else begin
            chk("s_req", {63'd0, s_req_o}, {63'd0, q_rreq.pop_front()});
            chk("s_addr", s_addr_o, q_raddr.pop_front());
            chk("s_wdata", s_wdata_o, q_rwdata.pop_front());
            chk("s_wstrb", {56'd0, s_wstrb_o}, {56'd0, q_rwstrb.pop_front()});
          end
          sn_req = s_req_o; sn_addr = s_addr_o; sn_wdata = s_wdata_o; sn_wstrb = s_wstrb_o;
        end else begin
          chk("stall_s_req", {63'd0, s_req_o}, {63'd0, sn_req});
          chk("stall_s_addr", s_addr_o, sn_addr);
          chk("stall_s_wdata", s_wdata_o, sn_wdata);
          chk("stall_s_wstrb", {56'd0, s_wstrb_o}, {56'd0, sn_wstrb});
        end
      end
      in_busy = s_valid_o;
      if (m0_ready_o && m1_ready_o) begin
        chk("both_ready", 64'd1, 64'd0);
      end else if (m0_ready_o || m1_ready_o) begin
        if (q_cid.size() == 0) begin
          chk("unexpected_ready", 64'd1, 64'd0);
        end else begin
          int ec;
          chk("ready_id", {63'd0, m1_ready_o}, {63'd0, q_cid.pop_front()});
          chk("rdata", m1_ready_o ? m1_rdata_o : m0_rdata_o, q_crdata.pop_front());
          chk("resp", {62'd0, m1_ready_o ? m1_resp_o : m0_resp_o}, {62'd0, q_cresp.pop_front()});
          ec = q_ccyc.pop_front();
          if (ec >= 0) chk("ready_cycle", 64'(cyc), 64'(ec));
        end
      end
    end
    chk("pending_requests", 64'(q_raddr.size()), 64'd0);
    chk("pending_completions", 64'(q_cid.size()), 64'd0);
    chk("timeouts", 64'(tmo), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic exp_req(input logic req, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wstrb);
    q_rreq.push_back(req); q_raddr.push_back(addr);
    q_rwdata.push_back(wdata); q_rwstrb.push_back(wstrb);
  endtask

  task automatic exp_cmp(input logic id, input logic [63:0] rdata, input logic [1:0] resp,
                         input int ecyc);
    q_cid.push_back(id); q_crdata.push_back(rdata);
    q_cresp.push_back(resp); q_ccyc.push_back(ecyc);
  endtask

  task automatic issue(input logic id, input logic req, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wstrb);
    if (id) begin
      m1_valid_i = 1'b1; m1_req_i = req; m1_addr_i = addr; m1_wdata_i = wdata; m1_wstrb_i = wstrb;
    end else begin
      m0_valid_i = 1'b1; m0_req_i = req; m0_addr_i = addr; m0_wdata_i = wdata; m0_wstrb_i = wstrb;
    end
  endtask

  // Masters drop valid after seeing their ready pulse; ends in an IDLE cycle.
  task automatic run_until_idle();
    int n = 0;
    do begin
      @(negedge clk);
      if (m0_ready_o) m0_valid_i = 1'b0;
      if (m1_ready_o) m1_valid_i = 1'b0;
      n++;
    end while ((m0_valid_i || m1_valid_i) && n < 200);
    if (m0_valid_i || m1_valid_i) begin
      $display("FAIL run_timeout: valids m0=%0d m1=%0d still high after %0d cycles",
               m0_valid_i, m1_valid_i, n);
      tmo++;
      m0_valid_i = 1'b0;
      m1_valid_i = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch read, zero-wait slave: ready in the third cycle.
    g_wait = 0; g_resp = 2'b00;
    exp_req(1'b0, 64'hbff8, 64'h0, 8'h00);
    exp_cmp(1'b0, 64'h1234, 2'b00, cyc + 2);
    issue(1'b0, 1'b0, 64'hbff8, 64'h0, 8'h00);
    run_until_idle();

    // Two ties in a row: load/store first, then fetch, in both policies.
    g_resp = 2'b10;
    exp_req(1'b1, 64'h4010, 64'hAA, 8'h0F);
    exp_cmp(1'b1, 64'h5A5A_0000_0000_4010, 2'b10, cyc + 2);
    exp_req(1'b0, 64'h4008, 64'h0, 8'h00);
    exp_cmp(1'b0, 64'h5A5A_0000_0000_4008, 2'b10, cyc + 5);
    issue(1'b0, 1'b0, 64'h4008, 64'h0, 8'h00);
    issue(1'b1, 1'b1, 64'h4010, 64'hAA, 8'h0F);
    run_until_idle();

    g_resp = 2'b01;
    exp_req(1'b0, 64'h4020, 64'h0, 8'h00);
    exp_cmp(1'b1, 64'h5A5A_0000_0000_4020, 2'b01, cyc + 2);
    exp_req(1'b0, 64'h4018, 64'h0, 8'h00);
    exp_cmp(1'b0, 64'h5A5A_0000_0000_4018, 2'b01, cyc + 5);
    issue(1'b0, 1'b0, 64'h4018, 64'h0, 8'h00);
    issue(1'b1, 1'b0, 64'h4020, 64'h0, 8'h00);
    run_until_idle();

    // Lone load/store, then a tie: the policies now disagree.
    g_resp = 2'b00;
    exp_req(1'b0, 64'h4030, 64'h0, 8'h00);
    exp_cmp(1'b1, 64'h5A5A_0000_0000_4030, 2'b00, cyc + 2);
    issue(1'b1, 1'b0, 64'h4030, 64'h0, 8'h00);
    run_until_idle();
`ifdef CLINT_ARB_RR_EN
    exp_req(1'b0, 64'h4038, 64'h0, 8'h00);
    exp_cmp(1'b0, 64'h5A5A_0000_0000_4038, 2'b00, cyc + 2);
    exp_req(1'b0, 64'h4040, 64'h0, 8'h00);
    exp_cmp(1'b1, 64'h5A5A_0000_0000_4040, 2'b00, cyc + 5);
`else
    exp_req(1'b0, 64'h4040, 64'h0, 8'h00);
    exp_cmp(1'b1, 64'h5A5A_0000_0000_4040, 2'b00, cyc + 2);
    exp_req(1'b0, 64'h4038, 64'h0, 8'h00);
    exp_cmp(1'b0, 64'h5A5A_0000_0000_4038, 2'b00, cyc + 5);
`endif
    issue(1'b0, 1'b0, 64'h4038, 64'h0, 8'h00);
    issue(1'b1, 1'b0, 64'h4040, 64'h0, 8'h00);
    run_until_idle();

    // Write with a 5-cycle slave stall: ready the cycle after s_ready_i.
    g_wait = 5;
    exp_req(1'b1, 64'h4000, 64'h10, 8'hFF);
    exp_cmp(1'b1, 64'h5A5A_0000_0000_4000, 2'b00, cyc + 7);
    issue(1'b1, 1'b1, 64'h4000, 64'h10, 8'hFF);
    run_until_idle();

    // Reset during BUSY: abandoned without a ready pulse, then a tie is
    // resolved with the pointer back at the load/store master.
    g_wait = 20;
    exp_req(1'b0, 64'h4048, 64'h0, 8'h00);
    issue(1'b0, 1'b0, 64'h4048, 64'h0, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    g_wait = 0;
    exp_req(1'b0, 64'h4050, 64'h0, 8'h00);
    exp_cmp(1'b1, 64'h5A5A_0000_0000_4050, 2'b00, cyc + 2);
    exp_req(1'b0, 64'h4048, 64'h0, 8'h00);
    exp_cmp(1'b0, 64'h5A5A_0000_0000_4048, 2'b00, cyc + 5);
    issue(1'b1, 1'b0, 64'h4050, 64'h0, 8'h00);
    run_until_idle();

    repeat (2) @(negedge clk);
    done = 1'b1;
  end

endmodule
